// File: rtl/pe_mmio_xbar_if.sv
`default_nettype none
// ============================================================================
// Module   : pe_mmio_xbar_if
// Purpose  : CPU-side and target-side bus bundle for the MMIO crossbar.
// Revision : 1.0 - initial release
// ============================================================================
// Signal suffixes (_i/_o) are relative to the crossbar; the slave modport is
// the crossbar itself, the master modport is the CPU plus target environment.
interface pe_mmio_xbar_if #(
  parameter int N_SLV = 4
);
  logic                   cpu_en_i;
  logic [3:0]             cpu_we_i;
  logic [31:0]            cpu_addr_i;
  logic [31:0]            cpu_data_i;
  logic [31:0]            cpu_data_o;
  logic                   cpu_stall_o;
  logic [N_SLV-1:0]       slv_en_o;
  logic [3:0]             slv_we_o;
  logic [31:0]            slv_addr_o;
  logic [31:0]            slv_data_o;
  logic [N_SLV-1:0][31:0] slv_data_i;
  logic [N_SLV-1:0]       slv_ready_i;
  logic                   err_o;
  logic [31:0]            err_addr_o;
  logic                   err_write_o;
  logic                   err_clr_i;

  modport slave (
    input  cpu_en_i, cpu_we_i, cpu_addr_i, cpu_data_i,
    input  slv_data_i, slv_ready_i, err_clr_i,
    output cpu_data_o, cpu_stall_o,
    output slv_en_o, slv_we_o, slv_addr_o, slv_data_o,
    output err_o, err_addr_o, err_write_o
  );

  modport master (
    output cpu_en_i, cpu_we_i, cpu_addr_i, cpu_data_i,
    output slv_data_i, slv_ready_i, err_clr_i,
    input  cpu_data_o, cpu_stall_o,
    input  slv_en_o, slv_we_o, slv_addr_o, slv_data_o,
    input  err_o, err_addr_o, err_write_o
  );
endinterface
`default_nettype wire

// File: rtl/pe_mmio_xbar.sv
`default_nettype none
// ============================================================================
// Module   : pe_mmio_xbar
// Purpose  : Single-master MMIO crossbar with address decode, stall timeout
//            abort and a first-error capture register.
// Revision : 1.0 - initial release
// ============================================================================
module pe_mmio_xbar #(
  parameter int          N_SLV           = 4,
  parameter logic [31:0] SLV_BASE [N_SLV] = '{32'h80000000, 32'hC1000000,
                                              32'hC2000000, 32'hC4000000},
  parameter logic [31:0] SLV_MASK [N_SLV] = '{32'hC0000000, 32'hFF000000,
                                              32'hFF000000, 32'hFF000000},
  parameter int          TIMEOUT         = 16,
  parameter logic [31:0] ERR_DATA        = 32'hDEADBEEF
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  pe_mmio_xbar_if.slave bus
);

  localparam int                 c_idx_w   = (N_SLV > 1) ? $clog2(N_SLV) : 1;
  localparam int                 c_cnt_w   = $clog2(TIMEOUT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(TIMEOUT);
  localparam logic [0:0]         c_st_idle = 1'b0;
  localparam logic [0:0]         c_st_wait = 1'b1;
  // Read-select MSB flags "return ERR_DATA" instead of a target index.
  localparam logic [c_idx_w:0]   c_sel_err = {1'b1, {c_idx_w{1'b0}}};

  logic [c_idx_w-1:0] w_hit_idx;
  logic               w_mapped;
  logic               w_ready;
  logic               w_read;
  logic               w_abort;
  logic               w_stall;
  logic               w_err_ev;
  logic [N_SLV-1:0]   w_slv_en;

  logic [0:0]         state_q, state_d;
  logic [c_cnt_w-1:0] cnt_q, cnt_d;
  logic [c_idx_w:0]   sel_q, sel_d;
  logic               err_q, err_d;
  logic [31:0]        err_addr_q, err_addr_d;
  logic               err_write_q, err_write_d;

  // Scan downwards so the lowest matching port is the last one written.
  always_comb begin : p_decode
    w_hit_idx = '0;
    w_mapped  = 1'b0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((bus.cpu_addr_i & SLV_MASK[i]) == SLV_BASE[i]) begin
        w_hit_idx = c_idx_w'(i);
        w_mapped  = 1'b1;
      end
    end
  end

  assign w_ready = bus.slv_ready_i[w_hit_idx];
  assign w_read  = bus.cpu_en_i && (bus.cpu_we_i == 4'b0000);

  always_ff @(posedge clk_i) begin : p_state_reg
    if (!rst_ni) begin
      state_q <= c_st_idle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any non-stalled cycle (completion, abort, idle) returns to IDLE.
  always_comb begin : p_next_state
    state_d = c_st_idle;
    cnt_d   = '0;
    if (w_stall) begin
      state_d = c_st_wait;
      cnt_d   = (cnt_q == c_cnt_max) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_comb begin : p_outputs
    w_abort  = 1'b0;
    w_stall  = 1'b0;
    w_slv_en = '0;
    if (rst_ni && bus.cpu_en_i && w_mapped) begin
      w_abort = (state_q == c_st_wait) && (cnt_q == c_cnt_max) && !w_ready;
      w_stall = !w_ready && !w_abort;
      if (!w_abort) begin
        w_slv_en[w_hit_idx] = 1'b1;
      end
    end
  end

  assign w_err_ev = bus.cpu_en_i && (!w_mapped || w_abort);

  // A clear in the same cycle as a new error lets the new error in.
  always_comb begin : p_data_next
    sel_d       = sel_q;
    err_d       = err_q;
    err_addr_d  = err_addr_q;
    err_write_d = err_write_q;
    if (w_read && w_mapped && w_ready) begin
      sel_d = {1'b0, w_hit_idx};
    end else if (w_read && (!w_mapped || w_abort)) begin
      sel_d = c_sel_err;
    end
    if (w_err_ev && (!err_q || bus.err_clr_i)) begin
      err_d       = 1'b1;
      err_addr_d  = bus.cpu_addr_i;
      err_write_d = |bus.cpu_we_i;
    end else if (bus.err_clr_i) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin : p_data_reg
    if (!rst_ni) begin
      sel_q       <= '0;
      err_q       <= 1'b0;
      err_addr_q  <= '0;
      err_write_q <= 1'b0;
    end else begin
      sel_q       <= sel_d;
      err_q       <= err_d;
      err_addr_q  <= err_addr_d;
      err_write_q <= err_write_d;
    end
  end

  assign bus.cpu_data_o  = sel_q[c_idx_w] ? ERR_DATA
                                          : bus.slv_data_i[sel_q[c_idx_w-1:0]];
  assign bus.cpu_stall_o = w_stall;
  assign bus.slv_en_o    = w_slv_en;
  assign bus.slv_we_o    = bus.cpu_we_i;
  assign bus.slv_addr_o  = bus.cpu_addr_i;
  assign bus.slv_data_o  = bus.cpu_data_i;
  assign bus.err_o       = err_q;
  assign bus.err_addr_o  = err_addr_q;
  assign bus.err_write_o = err_write_q;

endmodule
`default_nettype wire

// File: tb/tb_pe_mmio_xbar.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_mmio_xbar
// Purpose  : Self-checking bench for pe_mmio_xbar: vector table, timeout and
//            reset sequences, then random traffic against a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pe_mmio_xbar;

  localparam int          N    = 4;
  localparam int          TMO  = 16;
  localparam logic [31:0] ERRD = 32'hDEADBEEF;
  localparam logic [31:0] BASE [N] = '{32'h80000000, 32'hC1000000, 32'hC2000000, 32'hC4000000};
  localparam logic [31:0] MASK [N] = '{32'hC0000000, 32'hFF000000, 32'hFF000000, 32'hFF000000};
  localparam logic [31:0] DFIX [N] = '{32'h10000000, 32'h20000001, 32'h30000002, 32'h40000003};

  typedef struct {
    logic        rstn;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [3:0]  rdy;
    logic        clr;
    logic [3:0]  x_en;
    logic        x_stall;
    logic [31:0] x_data;
    logic        x_err;
    logic [31:0] x_eaddr;
    logic        x_ewr;
  } vec_t;

  logic clk = 1'b0;
  logic rst_ni;
  int   n_chk = 0;
  int   n_err = 0;
  vec_t tbl [$];
  logic [N-1:0][31:0] nxt_data;

  pe_mmio_xbar_if #(.N_SLV(N)) bus ();

  pe_mmio_xbar dut (
    .clk_i  (clk),
    .rst_ni (rst_ni),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, want %08h", name, act, exp);
    end
  endtask

  // Inputs change at the falling edge; checks follow 1 time unit later.
  task automatic drive(input logic rstn, input logic en, input logic [3:0] we,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [3:0] rdy, input logic clr);
    @(negedge clk);
    rst_ni          = rstn;
    bus.cpu_en_i    = en;
    bus.cpu_we_i    = we;
    bus.cpu_addr_i  = addr;
    bus.cpu_data_i  = wd;
    bus.slv_ready_i = rdy;
    bus.err_clr_i   = clr;
    bus.slv_data_i  = nxt_data;
    #1;
  endtask

  task automatic chk_bus(input string tag, input logic [3:0] x_en, input logic x_stall);
    chk({tag, " slv_en"}, 32'(bus.slv_en_o), 32'(x_en));
    chk({tag, " stall"}, 32'(bus.cpu_stall_o), 32'(x_stall));
    chk({tag, " fwd_we"}, 32'(bus.slv_we_o), 32'(bus.cpu_we_i));
    chk({tag, " fwd_addr"}, bus.slv_addr_o, bus.cpu_addr_i);
    chk({tag, " fwd_data"}, bus.slv_data_o, bus.cpu_data_i);
  endtask

  task automatic chk_err(input string tag, input logic x_err, input logic [31:0] x_addr, input logic x_wr);
    chk({tag, " err"}, 32'(bus.err_o), 32'(x_err));
    if (x_err) begin
      chk({tag, " err_addr"}, bus.err_addr_o, x_addr);
      chk({tag, " err_write"}, 32'(bus.err_write_o), 32'(x_wr));
    end
  endtask

  task automatic idle(input logic clr);
    drive(1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 4'h0, clr);
  endtask

  function automatic int hit_of(input logic [31:0] a);
    for (int i = 0; i < N; i++)
      if ((a & MASK[i]) == BASE[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 5))
      0:       return {2'b10, 30'($urandom)};
      1:       return {8'hC1, 24'($urandom)};
      2:       return {8'hC2, 24'($urandom)};
      3:       return {8'hC4, 24'($urandom)};
      4:       return {8'h00, 24'($urandom)};
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    string       tag;
    logic        r_rstn, r_en, r_clr, stuck, hold, aborted, errev;
    logic [3:0]  r_we, r_rdy, x_en;
    logic [31:0] r_addr, r_wd, x_data;
    logic        x_stall;
    int          h, m_wait, m_sel;
    logic        m_err, m_ewr;
    logic [31:0] m_eaddr;

    for (int i = 0; i < N; i++) nxt_data[i] = DFIX[i];
    rst_ni = 1'b0; bus.cpu_en_i = 1'b0; bus.cpu_we_i = '0; bus.cpu_addr_i = '0;
    bus.cpu_data_i = '0; bus.slv_ready_i = '0; bus.err_clr_i = 1'b0; bus.slv_data_i = nxt_data;

    //               rstn  en    we     addr          rdy    clr   x_en   stall x_data   err   eaddr         ewr
    tbl.push_back('{1'b0, 1'b1, 4'h0, 32'h80000010, 4'hF, 1'b0, 4'h0, 1'b0, DFIX[0], 1'b0, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 1'b1, 4'h0, 32'h80000010, 4'hF, 1'b0, 4'h1, 1'b0, DFIX[0], 1'b0, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 1'b1, 4'h0, 32'hC1000020, 4'hF, 1'b0, 4'h2, 1'b0, DFIX[0], 1'b0, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 1'b1, 4'h0, 32'hC2000000, 4'hF, 1'b0, 4'h4, 1'b0, DFIX[1], 1'b0, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 1'b1, 4'hF, 32'hC4000008, 4'hF, 1'b0, 4'h8, 1'b0, DFIX[2], 1'b0, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 32'h00000000, 4'h0, 1'b0, 4'h0, 1'b0, DFIX[2], 1'b0, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 1'b1, 4'h0, 32'h00001000, 4'hF, 1'b0, 4'h0, 1'b0, DFIX[2], 1'b0, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 32'h00000000, 4'h0, 1'b0, 4'h0, 1'b0, ERRD,    1'b1, 32'h00001000, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 4'h0, 32'h00000010, 4'hF, 1'b0, 4'h0, 1'b0, ERRD,    1'b1, 32'h00001000, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 32'h00000000, 4'h0, 1'b0, 4'h0, 1'b0, ERRD,    1'b1, 32'h00001000, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 32'h00000000, 4'h0, 1'b1, 4'h0, 1'b0, ERRD,    1'b1, 32'h00001000, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 32'h00000000, 4'h0, 1'b0, 4'h0, 1'b0, ERRD,    1'b0, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 1'b1, 4'h0, 32'h80000004, 4'hE, 1'b0, 4'h1, 1'b1, ERRD,    1'b0, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 1'b1, 4'h0, 32'h80000004, 4'h1, 1'b0, 4'h1, 1'b0, ERRD,    1'b0, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 32'h00000000, 4'h0, 1'b0, 4'h0, 1'b0, DFIX[0], 1'b0, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 1'b1, 4'h0, 32'h00000030, 4'hF, 1'b0, 4'h0, 1'b0, DFIX[0], 1'b0, 32'h0,        1'b0});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 32'h00000000, 4'h0, 1'b0, 4'h0, 1'b0, ERRD,    1'b1, 32'h00000030, 1'b0});
    tbl.push_back('{1'b1, 1'b1, 4'h3, 32'h00000020, 4'hF, 1'b1, 4'h0, 1'b0, ERRD,    1'b1, 32'h00000030, 1'b0});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 32'h00000000, 4'h0, 1'b0, 4'h0, 1'b0, ERRD,    1'b1, 32'h00000020, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 4'h0, 32'hC1000004, 4'h2, 1'b0, 4'h2, 1'b0, ERRD,    1'b1, 32'h00000020, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 32'h00000000, 4'h0, 1'b0, 4'h0, 1'b0, DFIX[1], 1'b1, 32'h00000020, 1'b1});
    tbl.push_back('{1'b1, 1'b1, 4'h0, 32'h40000000, 4'hF, 1'b0, 4'h0, 1'b0, DFIX[1], 1'b1, 32'h00000020, 1'b1});
    tbl.push_back('{1'b1, 1'b0, 4'h0, 32'h00000000, 4'h0, 1'b0, 4'h0, 1'b0, ERRD,    1'b1, 32'h00000020, 1'b1});

    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 4'h0, 1'b0);
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 4'h0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rstn, tbl[i].en, tbl[i].we, tbl[i].addr, 32'hA5A50000 + 32'(i), tbl[i].rdy, tbl[i].clr);
      tag = $sformatf("vec%0d", i);
      chk_bus(tag, tbl[i].x_en, tbl[i].x_stall);
      chk({tag, " rdata"}, bus.cpu_data_o, tbl[i].x_data);
      chk_err(tag, tbl[i].x_err, tbl[i].x_eaddr, tbl[i].x_ewr);
    end

    // Write stalled for exactly three cycles, completes on the fourth.
    idle(1'b1);
    idle(1'b0);
    chk_err("wstall pre", 1'b0, 32'h0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, 4'hF, 32'hC2000004, 32'h12345678, (k == 3) ? 4'h4 : 4'h0, 1'b0);
      chk_bus($sformatf("wstall c%0d", k), 4'h4, (k != 3));
    end
    idle(1'b0);
    chk_err("wstall post", 1'b0, 32'h0, 1'b0);
    chk("wstall rdata", bus.cpu_data_o, ERRD);

    // Ready arriving in the last allowed cycle completes normally.
    for (int k = 0; k <= TMO; k++) begin
      drive(1'b1, 1'b1, 4'h0, 32'hC4000000, 32'h0, (k == TMO) ? 4'h8 : 4'h0, 1'b0);
      chk_bus($sformatf("rwin c%0d", k), 4'h8, (k != TMO));
    end
    idle(1'b0);
    chk("rwin rdata", bus.cpu_data_o, DFIX[3]);
    chk_err("rwin", 1'b0, 32'h0, 1'b0);

    // Ready stuck low: TIMEOUT stall cycles, then abort.
    for (int k = 0; k <= TMO; k++) begin
      drive(1'b1, 1'b1, 4'h0, 32'hC4000000, 32'h0, 4'h0, 1'b0);
      chk_bus($sformatf("abort c%0d", k), (k == TMO) ? 4'h0 : 4'h8, (k != TMO));
    end
    idle(1'b0);
    chk("abort rdata", bus.cpu_data_o, ERRD);
    chk_err("abort", 1'b1, 32'hC4000000, 1'b0);

    // Reset during WAIT: counter restarts, record cleared.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 4'h0, 32'hC1000000, 32'h0, 4'h0, 1'b0);
      chk_bus($sformatf("rstw pre%0d", k), 4'h2, 1'b1);
    end
    drive(1'b0, 1'b1, 4'h0, 32'hC1000000, 32'h0, 4'h0, 1'b0);
    chk_bus("rstw inrst", 4'h0, 1'b0);
    for (int k = 0; k <= TMO; k++) begin
      drive(1'b1, 1'b1, 4'h0, 32'hC1000000, 32'h0, 4'h0, 1'b0);
      if (k == 0) begin
        chk_err("rstw post", 1'b0, 32'h0, 1'b0);
        chk("rstw rdata", bus.cpu_data_o, DFIX[0]);
      end
      chk_bus($sformatf("rstw c%0d", k), (k == TMO) ? 4'h0 : 4'h2, (k != TMO));
    end
    idle(1'b0);
    chk_err("rstw abort", 1'b1, 32'hC1000000, 1'b0);

    // Random traffic against the reference model.
    drive(1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 4'h0, 1'b0);
    m_wait = 0; m_sel = 0; m_err = 1'b0; m_eaddr = '0; m_ewr = 1'b0; hold = 1'b0;
    r_en = 1'b0; r_we = '0; r_addr = '0; r_wd = '0; stuck = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if (!hold) begin
        r_en   = ($urandom_range(0, 4) != 0);
        r_we   = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
        r_addr = pick_addr();
        r_wd   = $urandom();
        stuck  = ($urandom_range(0, 7) == 0);
      end
      r_rstn = ($urandom_range(0, 299) != 0);
      r_clr  = ($urandom_range(0, 9) == 0);
      r_rdy  = 4'($urandom_range(0, 15));
      h      = hit_of(r_addr);
      if (stuck && h >= 0) r_rdy[h] = 1'b0;
      for (int i = 0; i < N; i++) nxt_data[i] = $urandom();
      drive(r_rstn, r_en, r_we, r_addr, r_wd, r_rdy, r_clr);

      x_en = 4'h0; x_stall = 1'b0; aborted = 1'b0;
      if (r_rstn && r_en && h >= 0) begin
        if (r_rdy[h]) x_en = 4'(1 << h);
        else if (m_wait == TMO) aborted = 1'b1;
        else begin
          x_en    = 4'(1 << h);
          x_stall = 1'b1;
        end
      end
      x_data = (m_sel < 0) ? ERRD : nxt_data[m_sel];
      tag = $sformatf("rnd%0d", c);
      chk_bus(tag, x_en, x_stall);
      chk({tag, " rdata"}, bus.cpu_data_o, x_data);
      chk_err(tag, m_err, m_eaddr, m_ewr);

      if (!r_rstn) begin
        m_wait = 0; m_sel = 0; m_err = 1'b0; m_eaddr = '0; m_ewr = 1'b0;
      end else begin
        m_wait = x_stall ? m_wait + 1 : 0;
        if (r_en && r_we == 4'h0) begin
          if (h >= 0 && r_rdy[h]) m_sel = h;
          else if (h < 0 || aborted) m_sel = -1;
        end
        errev = r_en && (h < 0 || aborted);
        if (errev && (!m_err || r_clr)) begin
          m_err = 1'b1; m_eaddr = r_addr; m_ewr = (r_we != 4'h0);
        end else if (r_clr) begin
          m_err = 1'b0;
        end
      end
      hold = x_stall;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
